// File: rtl/ram_seq_pkg.sv
// ram_seq_pkg: state type, hold-counter sizing and CNT_MAX defaults for the RAM sequencer.
package ram_seq_pkg;
    typedef enum logic [1:0] {IDLE, WRITE, READ} state_t;
    localparam int unsigned CNT_MAX_SYN = 12_499_999;
    localparam int unsigned CNT_MAX_SIM = 10;
    function automatic int unsigned cnt_w(input int unsigned cnt_max);
        return (cnt_max < 2) ? 1 : $clog2(cnt_max);
    endfunction
endpackage

// File: rtl/ram_seq_hold_cnt.sv
// ram_seq_hold_cnt: counts 0..CNT_MAX-1 while enabled; tc marks the last cycle of each hold period.
module ram_seq_hold_cnt
    import ram_seq_pkg::*;
#(
    parameter int unsigned CNT_MAX = CNT_MAX_SYN
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tc
);
    localparam int unsigned W = cnt_w(CNT_MAX);
    localparam logic [W-1:0] LAST = W'(CNT_MAX - 1);
    logic [W-1:0] cnt;
    assign tc = en && cnt == LAST;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) cnt <= '0;
        else if (clr) cnt <= '0;
        else if (en) cnt <= tc ? '0 : cnt + W'(1);
endmodule

// File: rtl/ram_seq_ctrl.sv
// ram_seq_ctrl: burst-fill and wrapping read-scan sequencer for a single-port synchronous RAM.
// Define RAM_SEQ_CTRL_CHECK_EN to add the read-back checker (rd_data in, err/err_cnt out).
module ram_seq_ctrl
    import ram_seq_pkg::*;
#(
    parameter int unsigned ADDR_W     = 8,
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned DEPTH      = 256,
    parameter int unsigned CNT_MAX    = CNT_MAX_SYN,
    parameter int unsigned DATA_START = 0,
    parameter int unsigned RD_LAT     = 1
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic              wr_flag,
    input  logic              rd_flag,
    output logic              wr_en,
    output logic              rd_en,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              busy,
    output logic              wr_done
`ifdef RAM_SEQ_CTRL_CHECK_EN
    ,
    input  logic [DATA_W-1:0] rd_data,
    output logic              err,
    output logic [15:0]       err_cnt
`endif
);
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);
    localparam logic [DATA_W-1:0] SEED = DATA_W'(DATA_START);

    if (RD_LAT >= CNT_MAX || CNT_MAX < 2 || DEPTH < 2 || 64'(DEPTH) > (64'd1 << ADDR_W)) begin : g_bad_cfg
        $error("ram_seq_ctrl: invalid DEPTH/CNT_MAX/RD_LAT");
    end

    state_t state, state_d;
    logic rd_pend, rd_pend_d, wr_en_d, rd_en_d, wr_done_d, tc, pend_eff;
    logic [ADDR_W-1:0] addr_d;

    ram_seq_hold_cnt #(.CNT_MAX(CNT_MAX)) u_hold (
        .clk   (sys_clk),
        .rst_n (sys_rst_n),
        .clr   (state != READ || wr_flag || rd_flag),
        .en    (state == READ),
        .tc    (tc)
    );

    // A rd_flag on the final write cycle still counts toward the resume decision.
    assign pend_eff = rd_pend ^ rd_flag;

    always_comb begin
        state_d   = state;
        wr_en_d   = 1'b0;
        rd_en_d   = 1'b0;
        wr_done_d = 1'b0;
        addr_d    = addr;
        rd_pend_d = rd_pend;
        case (state)
            IDLE: begin
                state_d   = wr_flag ? WRITE : rd_flag ? READ : IDLE;
                wr_en_d   = wr_flag;
                rd_en_d   = !wr_flag && rd_flag;
                addr_d    = '0;
                rd_pend_d = wr_flag && rd_flag;
            end
            WRITE: begin
                if (addr == LAST) begin
                    state_d   = pend_eff ? READ : IDLE;
                    rd_en_d   = pend_eff;
                    wr_done_d = 1'b1;
                    addr_d    = '0;
                    rd_pend_d = 1'b0;
                end else begin
                    wr_en_d   = 1'b1;
                    addr_d    = addr + ADDR_W'(1);
                    rd_pend_d = pend_eff;
                end
            end
            READ: begin
                if (wr_flag) begin
                    state_d   = WRITE;
                    wr_en_d   = 1'b1;
                    addr_d    = '0;
                    rd_pend_d = !rd_flag;
                end else if (rd_flag) begin
                    state_d = IDLE;
                    addr_d  = '0;
                end else begin
                    rd_en_d = 1'b1;
                    addr_d  = !tc ? addr : (addr == LAST) ? '0 : addr + ADDR_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n)
        if (!sys_rst_n) begin
            state   <= IDLE;
            wr_en   <= 1'b0;
            rd_en   <= 1'b0;
            addr    <= '0;
            wr_data <= '0;
            busy    <= 1'b0;
            wr_done <= 1'b0;
            rd_pend <= 1'b0;
        end else begin
            state   <= state_d;
            wr_en   <= wr_en_d;
            rd_en   <= rd_en_d;
            addr    <= addr_d;
            wr_data <= wr_en_d ? SEED + DATA_W'(addr_d) : '0;
            busy    <= state_d != IDLE;
            wr_done <= wr_done_d;
            rd_pend <= rd_pend_d;
        end

`ifdef RAM_SEQ_CTRL_CHECK_EN
    // Compare at the end of each hold period, well past the RAM read latency.
    logic wr_seen;
    always_ff @(posedge sys_clk or negedge sys_rst_n)
        if (!sys_rst_n) begin
            wr_seen <= 1'b0;
            err     <= 1'b0;
            err_cnt <= '0;
        end else begin
            if (wr_done) wr_seen <= 1'b1;
            if (tc && wr_seen && rd_data != SEED + DATA_W'(addr)) begin
                err <= 1'b1;
                if (err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
            end
        end
`endif
endmodule

// File: tb/tb_ram_seq_ctrl.sv
// tb_ram_seq_ctrl: directed checks of fill, read scan, preemption, flag arbitration and reset.
module tb_ram_seq_ctrl;
    logic sys_clk = 1'b0, sys_rst_n = 1'b1;
    logic wr_flag = 1'b0, rd_flag = 1'b0, wr_flag2 = 1'b0, rd_flag2 = 1'b0;
    logic wr_en, rd_en, busy, wr_done, wr_en2, rd_en2, busy2, wr_done2;
    logic [7:0] addr, wr_data, addr2, wr_data2;
    logic [19:0] obs, obs2, want;
    int vectors = 0, miscompares = 0;

    always #5 sys_clk = ~sys_clk;
    assign obs  = {wr_en, rd_en, busy, wr_done, addr, wr_data};
    assign obs2 = {wr_en2, rd_en2, busy2, wr_done2, addr2, wr_data2};

`ifdef RAM_SEQ_CTRL_CHECK_EN
    logic [7:0] mem [256], mem2 [256];
    logic [7:0] ra, ra2, rd_data, rd_data2;
    logic err, err2;
    logic [15:0] err_cnt, err_cnt2;
    always @(posedge sys_clk) begin
        if (wr_en) mem[addr] <= wr_data;
        if (wr_en2) mem2[addr2] <= wr_data2;
        ra  <= addr;
        ra2 <= addr2;
    end
    assign rd_data  = mem[ra];
    assign rd_data2 = mem2[ra2];
`endif

    ram_seq_ctrl #(.CNT_MAX(10)) dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .wr_flag(wr_flag), .rd_flag(rd_flag),
        .wr_en(wr_en), .rd_en(rd_en), .addr(addr), .wr_data(wr_data), .busy(busy), .wr_done(wr_done)
`ifdef RAM_SEQ_CTRL_CHECK_EN
        , .rd_data(rd_data), .err(err), .err_cnt(err_cnt)
`endif
    );

    ram_seq_ctrl #(.CNT_MAX(10), .DEPTH(20), .DATA_START(8'hF0)) dut2 (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .wr_flag(wr_flag2), .rd_flag(rd_flag2),
        .wr_en(wr_en2), .rd_en(rd_en2), .addr(addr2), .wr_data(wr_data2), .busy(busy2), .wr_done(wr_done2)
`ifdef RAM_SEQ_CTRL_CHECK_EN
        , .rd_data(rd_data2), .err(err2), .err_cnt(err_cnt2)
`endif
    );

    function automatic logic [19:0] vec(input logic w, r, b, d, input logic [7:0] a, dt);
        return {w, r, b, d, a, dt};
    endfunction

    task automatic pulse(input logic w, input logic r);
        @(negedge sys_clk);
        wr_flag = w;
        rd_flag = r;
        @(negedge sys_clk);
        wr_flag = 1'b0;
        rd_flag = 1'b0;
    endtask

    task automatic test_reset();
        #1 sys_rst_n = 1'b0;
        repeat (2) @(negedge sys_clk);
        vectors++;
        if (obs !== 20'h0) begin miscompares++; $display("FAIL reset_state got=%h want=%h", obs, 20'h0); end
        vectors++;
        if (obs2 !== 20'h0) begin miscompares++; $display("FAIL reset_state2 got=%h want=%h", obs2, 20'h0); end
        sys_rst_n = 1'b1;
        repeat (2) @(negedge sys_clk);
        vectors++;
        if (obs !== 20'h0) begin miscompares++; $display("FAIL reset_release got=%h want=%h", obs, 20'h0); end
    endtask

    task automatic test_read_first();
        pulse(1'b0, 1'b1);
        for (int t = 0; t < 2570; t++) begin
            want = vec(1'b0, 1'b1, 1'b1, 1'b0, 8'((t / 10) % 256), 8'h0);
            vectors++;
            if (obs !== want) begin miscompares++; $display("FAIL read_scan t=%0d got=%h want=%h", t, obs, want); end
            @(negedge sys_clk);
        end
        pulse(1'b0, 1'b1);
        vectors++;
        if (obs !== 20'h0) begin miscompares++; $display("FAIL read_stop got=%h want=%h", obs, 20'h0); end
    endtask

    task automatic test_write();
        pulse(1'b1, 1'b0);
        for (int i = 0; i < 256; i++) begin
            wr_flag = (i == 50);
            want = vec(1'b1, 1'b0, 1'b1, 1'b0, 8'(i), 8'(i));
            vectors++;
            if (obs !== want) begin miscompares++; $display("FAIL write_fill i=%0d got=%h want=%h", i, obs, want); end
            @(negedge sys_clk);
        end
        wr_flag = 1'b0;
        want = vec(1'b0, 1'b0, 1'b0, 1'b1, 8'h0, 8'h0);
        vectors++;
        if (obs !== want) begin miscompares++; $display("FAIL write_done got=%h want=%h", obs, want); end
        @(negedge sys_clk);
        vectors++;
        if (obs !== 20'h0) begin miscompares++; $display("FAIL write_idle got=%h want=%h", obs, 20'h0); end
    endtask

    task automatic test_preempt();
        pulse(1'b0, 1'b1);
        for (int t = 0; t < 373; t++) begin
            want = vec(1'b0, 1'b1, 1'b1, 1'b0, 8'(t / 10), 8'h0);
            vectors++;
            if (obs !== want) begin miscompares++; $display("FAIL preempt_scan t=%0d got=%h want=%h", t, obs, want); end
            @(negedge sys_clk);
        end
        pulse(1'b1, 1'b0);
        for (int i = 0; i < 256; i++) begin
            want = vec(1'b1, 1'b0, 1'b1, 1'b0, 8'(i), 8'(i));
            vectors++;
            if (obs !== want) begin miscompares++; $display("FAIL preempt_fill i=%0d got=%h want=%h", i, obs, want); end
            @(negedge sys_clk);
        end
        for (int t = 0; t < 30; t++) begin
            want = vec(1'b0, 1'b1, 1'b1, t == 0, 8'(t / 10), 8'h0);
            vectors++;
            if (obs !== want) begin miscompares++; $display("FAIL preempt_resume t=%0d got=%h want=%h", t, obs, want); end
            @(negedge sys_clk);
        end
`ifdef RAM_SEQ_CTRL_CHECK_EN
        repeat (2560) @(negedge sys_clk);
        vectors++;
        if (err !== 1'b0 || err_cnt !== 16'h0) begin
            miscompares++; $display("FAIL check_scan err=%b err_cnt=%0d want 0/0", err, err_cnt);
        end
`endif
        pulse(1'b0, 1'b1);
        vectors++;
        if (obs !== 20'h0) begin miscompares++; $display("FAIL preempt_stop got=%h want=%h", obs, 20'h0); end
    endtask

    task automatic test_both_flags();
        pulse(1'b1, 1'b1);
        for (int i = 0; i < 256; i++) begin
            want = vec(1'b1, 1'b0, 1'b1, 1'b0, 8'(i), 8'(i));
            vectors++;
            if (obs !== want) begin miscompares++; $display("FAIL both_fill i=%0d got=%h want=%h", i, obs, want); end
            @(negedge sys_clk);
        end
        want = vec(1'b0, 1'b1, 1'b1, 1'b1, 8'h0, 8'h0);
        vectors++;
        if (obs !== want) begin miscompares++; $display("FAIL both_to_read got=%h want=%h", obs, want); end
        pulse(1'b0, 1'b1);
        vectors++;
        if (obs !== 20'h0) begin miscompares++; $display("FAIL both_stop got=%h want=%h", obs, 20'h0); end
        pulse(1'b1, 1'b1);
        for (int i = 0; i < 256; i++) begin
            rd_flag = (i == 100);
            want = vec(1'b1, 1'b0, 1'b1, 1'b0, 8'(i), 8'(i));
            vectors++;
            if (obs !== want) begin miscompares++; $display("FAIL cancel_fill i=%0d got=%h want=%h", i, obs, want); end
            @(negedge sys_clk);
        end
        rd_flag = 1'b0;
        want = vec(1'b0, 1'b0, 1'b0, 1'b1, 8'h0, 8'h0);
        vectors++;
        if (obs !== want) begin miscompares++; $display("FAIL cancel_to_idle got=%h want=%h", obs, want); end
    endtask

    task automatic test_both_in_read();
        pulse(1'b0, 1'b1);
        repeat (15) @(negedge sys_clk);
        want = vec(1'b0, 1'b1, 1'b1, 1'b0, 8'h1, 8'h0);
        vectors++;
        if (obs !== want) begin miscompares++; $display("FAIL rd_hold got=%h want=%h", obs, want); end
        pulse(1'b1, 1'b1);
        for (int i = 0; i < 256; i++) begin
            want = vec(1'b1, 1'b0, 1'b1, 1'b0, 8'(i), 8'(i));
            vectors++;
            if (obs !== want) begin miscompares++; $display("FAIL stopwin_fill i=%0d got=%h want=%h", i, obs, want); end
            @(negedge sys_clk);
        end
        want = vec(1'b0, 1'b0, 1'b0, 1'b1, 8'h0, 8'h0);
        vectors++;
        if (obs !== want) begin miscompares++; $display("FAIL stopwin_idle got=%h want=%h", obs, want); end
    endtask

    task automatic test_small_depth();
        @(negedge sys_clk) wr_flag2 = 1'b1;
        @(negedge sys_clk) wr_flag2 = 1'b0;
        for (int i = 0; i < 20; i++) begin
            want = vec(1'b1, 1'b0, 1'b1, 1'b0, 8'(i), 8'(8'hF0 + i));
            vectors++;
            if (obs2 !== want) begin miscompares++; $display("FAIL seed_fill i=%0d got=%h want=%h", i, obs2, want); end
            @(negedge sys_clk);
        end
        want = vec(1'b0, 1'b0, 1'b0, 1'b1, 8'h0, 8'h0);
        vectors++;
        if (obs2 !== want) begin miscompares++; $display("FAIL seed_done got=%h want=%h", obs2, want); end
        @(negedge sys_clk) rd_flag2 = 1'b1;
        @(negedge sys_clk) rd_flag2 = 1'b0;
        for (int t = 0; t < 210; t++) begin
            want = vec(1'b0, 1'b1, 1'b1, 1'b0, 8'((t / 10) % 20), 8'h0);
            vectors++;
            if (obs2 !== want) begin miscompares++; $display("FAIL seed_scan t=%0d got=%h want=%h", t, obs2, want); end
            @(negedge sys_clk);
        end
`ifdef RAM_SEQ_CTRL_CHECK_EN
        vectors++;
        if (err2 !== 1'b0) begin miscompares++; $display("FAIL seed_check err=%b want 0", err2); end
`endif
        @(negedge sys_clk) rd_flag2 = 1'b1;
        @(negedge sys_clk) rd_flag2 = 1'b0;
        vectors++;
        if (obs2 !== 20'h0) begin miscompares++; $display("FAIL seed_stop got=%h want=%h", obs2, 20'h0); end
    endtask

    task automatic test_reset_mid();
        pulse(1'b1, 1'b0);
        for (int i = 0; i <= 100; i++) begin
            want = vec(1'b1, 1'b0, 1'b1, 1'b0, 8'(i), 8'(i));
            vectors++;
            if (obs !== want) begin miscompares++; $display("FAIL abort_fill i=%0d got=%h want=%h", i, obs, want); end
            if (i < 100) @(negedge sys_clk);
        end
        #2 sys_rst_n = 1'b0;
        #1;
        vectors++;
        if (obs !== 20'h0) begin miscompares++; $display("FAIL reset_async got=%h want=%h", obs, 20'h0); end
        @(negedge sys_clk) sys_rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge sys_clk);
            vectors++;
            if (obs !== 20'h0) begin miscompares++; $display("FAIL reset_no_resume k=%0d got=%h want=%h", k, obs, 20'h0); end
        end
`ifdef RAM_SEQ_CTRL_CHECK_EN
        vectors++;
        if (err_cnt !== 16'h0) begin miscompares++; $display("FAIL reset_err_cnt got=%0d want=0", err_cnt); end
`endif
    endtask

    initial begin
        test_reset();
        test_read_first();
        test_write();
        test_preempt();
        test_both_flags();
        test_both_in_read();
        test_small_depth();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
